// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive chains:
// parity and baud encodings, frame length, and the transmitter state enum.
package uart_pkg;

  // Parity encodings. 2'b11 is also treated as "none".
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Baud encodings and the baud rates they select.
  localparam logic [1:0] BAUD_SEL_2400  = 2'b00;
  localparam logic [1:0] BAUD_SEL_4800  = 2'b01;
  localparam logic [1:0] BAUD_SEL_9600  = 2'b10;
  localparam logic [1:0] BAUD_SEL_19200 = 2'b11;

  localparam int BAUD_2400  = 2400;
  localparam int BAUD_4800  = 4800;
  localparam int BAUD_9600  = 9600;
  localparam int BAUD_19200 = 19200;

  // Start + 8 data + parity + stop.
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Parity bit for a byte; unknown/none types send a constant 1 so the
  // frame length never changes.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] ptype);
    logic p;
    case (ptype)
      PAR_ODD:  p = ~^data;
      PAR_EVEN: p = ^data;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Per-bit baud counter for the UART transmitter. Counts 0..div-1 while
// enabled and flags bit_done on the last count of each bit period.
module uart_tx_baud_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             enable,
  input  logic [CNT_W-1:0] div,
  output logic             bit_done
);

  logic [CNT_W-1:0] cnt;

  assign bit_done = enable && (cnt == div - CNT_W'(1));

  // Free-running bit counter, held at zero while idle and re-zeroed on accept.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      cnt <= '0;
    end else if (restart || !enable || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop.
// Optional feature macro: UART_TX_TWO_STOP_EN (two stop bits, 12-bit frame).
module uart_tx_unit #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              send,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        parity_type,
  input  logic [1:0]        baud_rate,
  output logic              data_tx,
  output logic              active_flag,
  output logic              done_flag
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(CLK_FREQ / BAUD_2400 + 1);

  localparam logic [CNT_W-1:0] DIV_2400  = CNT_W'(CLK_FREQ / BAUD_2400);
  localparam logic [CNT_W-1:0] DIV_4800  = CNT_W'(CLK_FREQ / BAUD_4800);
  localparam logic [CNT_W-1:0] DIV_9600  = CNT_W'(CLK_FREQ / BAUD_9600);
  localparam logic [CNT_W-1:0] DIV_19200 = CNT_W'(CLK_FREQ / BAUD_19200);

  tx_state_t         state, next_state;
  logic [DATA_W-1:0] shreg;
  logic              par_q;
  logic [CNT_W-1:0]  div_q, div_sel;
  logic [2:0]        bit_idx;
  logic              accept;
  logic              bit_done;
  logic              stop_last;
  logic              tx_d;

  // Divisor selected by the current baud encoding; only latched on accept.
  always_comb begin
    case (baud_rate)
      BAUD_SEL_2400:  div_sel = DIV_2400;
      BAUD_SEL_4800:  div_sel = DIV_4800;
      BAUD_SEL_9600:  div_sel = DIV_9600;
      default:        div_sel = DIV_19200;
    endcase
  end

  uart_tx_baud_cnt #(
    .CNT_W (CNT_W)
  ) u_baud_cnt (
    .clock    (clock),
    .reset    (reset),
    .restart  (accept),
    .enable   (state != TX_IDLE),
    .div      (div_q),
    .bit_done (bit_done)
  );

`ifdef UART_TX_TWO_STOP_EN
  logic stop_second;

  // Tracks which of the two stop bits is being sent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stop_second <= 1'b0;
    end else if (state != TX_STOP) begin
      stop_second <= 1'b0;
    end else if (bit_done) begin
      stop_second <= ~stop_second;
    end
  end

  assign stop_last = stop_second;
`else
  assign stop_last = 1'b1;
`endif

  // Next-state logic; a send in the final stop cycle starts the next frame
  // on the same edge so there is no idle gap between frames.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    next_state = state;
    accept     = 1'b0;
    done_flag  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (send) begin
          accept     = 1'b1;
          next_state = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) next_state = TX_DATA;
      end
      TX_DATA: begin
        if (bit_done && bit_idx == 3'(DATA_W - 1)) next_state = TX_PARITY;
      end
      TX_PARITY: begin
        if (bit_done) next_state = TX_STOP;
      end
      TX_STOP: begin
        if (bit_done && stop_last) begin
          done_flag = 1'b1;
          if (send) begin
            accept     = 1'b1;
            next_state = TX_START;
          end else begin
            next_state = TX_IDLE;
          end
        end
      end
      default: next_state = TX_IDLE;
    endcase
  end

  // Line value for the cycle after this edge, chosen from the next state.
  always_comb begin
    tx_d = 1'b1;
    case (next_state)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = (state == TX_DATA && bit_done) ? shreg[1] : shreg[0];
      TX_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  assign active_flag = (state != TX_IDLE);

  // State, registered line output, and the latched frame contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      data_tx <= 1'b1;
      shreg   <= '0;
      par_q   <= 1'b1;
      div_q   <= DIV_2400;
      bit_idx <= '0;
    end else begin
      state   <= next_state;
      data_tx <= tx_d;
      if (accept) begin
        shreg   <= data_in;
        par_q   <= parity_bit(data_in, parity_type);
        div_q   <= div_sel;
        bit_idx <= '0;
      end else if (state == TX_DATA && bit_done) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed testbench for uart_tx_unit at CLK_FREQ=96000 (DIV=5 at 19200,
// DIV=10 at 9600). Honours UART_TX_TWO_STOP_EN for the frame length.
module tb_uart_tx_unit;
  import uart_pkg::*;

  localparam int CLK_FREQ = 96000;
`ifdef UART_TX_TWO_STOP_EN
  localparam int N_BITS = FRAME_BITS + 1;
`else
  localparam int N_BITS = FRAME_BITS;
`endif

  logic       clock;
  logic       reset;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_unit #(
    .CLK_FREQ (CLK_FREQ),
    .DATA_W   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected line value for frame bit b: start, data LSB first, parity, stops.
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return p;
    return 1'b1;
  endfunction

  // Request a frame; the accepting edge is the next rising edge.
  task automatic start_frame(input logic [7:0] d, input logic [1:0] ptype,
                             input logic [1:0] baud);
    @(negedge clock);
    data_in     = d;
    parity_type = ptype;
    baud_rate   = baud;
    send        = 1'b1;
  endtask

  // Checks ncyc cycles after an accepting edge. Optionally disturbs the
  // inputs at cycle 20 or chains a new send into the done cycle.
  task automatic run_frame(input string name, input logic [7:0] d, input logic p,
                           input int div, input int ncyc, input bit disturb,
                           input bit chain, input logic [7:0] chain_data);
    int total;
    total = N_BITS * div;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      send = 1'b0;
      n_checks++;
      if (data_tx !== exp_bit(d, p, (k - 1) / div)) begin
        n_fail++;
        $display("FAIL %s data_tx cycle %0d: got %b expected %b",
                 name, k, data_tx, exp_bit(d, p, (k - 1) / div));
      end
      n_checks++;
      if (active_flag !== 1'b1) begin
        n_fail++;
        $display("FAIL %s active_flag cycle %0d: got %b expected 1", name, k, active_flag);
      end
      n_checks++;
      if (done_flag !== (k == total)) begin
        n_fail++;
        $display("FAIL %s done_flag cycle %0d: got %b expected %b",
                 name, k, done_flag, (k == total));
      end
      if (disturb && k == 20) begin
        send        = 1'b1;
        data_in     = 8'hFF;
        baud_rate   = BAUD_SEL_2400;
        parity_type = PAR_ODD;
      end
      if (chain && k == total) begin
        send    = 1'b1;
        data_in = chain_data;
      end
    end
  endtask

  task automatic check_idle(input string name, input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      send = 1'b0;
      n_checks++;
      if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: got tx=%b active=%b done=%b expected 1/0/0",
                 name, k, data_tx, active_flag, done_flag);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got tx=%b active=%b done=%b expected 1/0/0",
               data_tx, active_flag, done_flag);
    end
    reset = 1'b0;
    check_idle("after_reset", 3);
  endtask

  task automatic test_even_parity();
    // A5 has four ones: even parity bit 0.
    start_frame(8'hA5, PAR_EVEN, BAUD_SEL_19200);
    run_frame("even_a5", 8'hA5, 1'b0, 5, N_BITS * 5, 1'b0, 1'b0, 8'h00);
    check_idle("even_a5_end", 2);
  endtask

  task automatic test_odd_parity();
    start_frame(8'h00, PAR_ODD, BAUD_SEL_19200);
    run_frame("odd_00", 8'h00, 1'b1, 5, N_BITS * 5, 1'b0, 1'b0, 8'h00);
    check_idle("odd_00_end", 2);
    start_frame(8'h01, PAR_ODD, BAUD_SEL_19200);
    run_frame("odd_01", 8'h01, 1'b0, 5, N_BITS * 5, 1'b0, 1'b0, 8'h00);
    check_idle("odd_01_end", 2);
  endtask

  task automatic test_no_parity();
    start_frame(8'hFF, PAR_NONE, BAUD_SEL_19200);
    run_frame("none_ff", 8'hFF, 1'b1, 5, N_BITS * 5, 1'b0, 1'b0, 8'h00);
    check_idle("none_ff_end", 2);
    start_frame(8'hA5, 2'b11, BAUD_SEL_19200);
    run_frame("none11_a5", 8'hA5, 1'b1, 5, N_BITS * 5, 1'b0, 1'b0, 8'h00);
    check_idle("none11_a5_end", 2);
  endtask

  task automatic test_config_change();
    // 3C has four ones: even parity 0. Mid-frame send/config changes ignored.
    start_frame(8'h3C, PAR_EVEN, BAUD_SEL_9600);
    run_frame("cfg_3c", 8'h3C, 1'b0, 10, N_BITS * 10, 1'b1, 1'b0, 8'h00);
    check_idle("cfg_no_ff", 40);
    baud_rate   = BAUD_SEL_19200;
    parity_type = PAR_EVEN;
  endtask

  task automatic test_back_to_back();
    start_frame(8'hA5, PAR_EVEN, BAUD_SEL_19200);
    run_frame("b2b_a5", 8'hA5, 1'b0, 5, N_BITS * 5, 1'b0, 1'b1, 8'h55);
    // 55 has four ones: even parity 0; starts with no idle cycle.
    run_frame("b2b_55", 8'h55, 1'b0, 5, N_BITS * 5, 1'b0, 1'b0, 8'h00);
    check_idle("b2b_end", 2);
  endtask

  task automatic test_mid_frame_reset();
    start_frame(8'h0F, PAR_EVEN, BAUD_SEL_19200);
    // Cycle 28 is inside data bit 4 (a 0 for 8'h0F).
    run_frame("rst_0f", 8'h0F, 1'b0, 5, 28, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    #1;
    n_checks++;
    if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got tx=%b active=%b done=%b expected 1/0/0",
               data_tx, active_flag, done_flag);
    end
    @(negedge clock);
    reset = 1'b0;
    check_idle("post_reset", 60);
    // 81 has two ones: even parity 0.
    start_frame(8'h81, PAR_EVEN, BAUD_SEL_19200);
    run_frame("clean_81", 8'h81, 1'b0, 5, N_BITS * 5, 1'b0, 1'b0, 8'h00);
    check_idle("clean_81_end", 2);
  endtask

  initial begin
    reset       = 1'b1;
    send        = 1'b0;
    data_in     = 8'h00;
    parity_type = PAR_NONE;
    baud_rate   = BAUD_SEL_19200;
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity();
    test_config_change();
    test_back_to_back();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
